toggle_energy_meter: RTL and testbench
======================================

TOGGLE_ENERGY_METER -- requirements
Module: toggle_energy_meter

Interface
REQ-001 Parameters SHALL be:
- WINDOW, 256, measurement window length in clk cycles (>=2).
- CNT_W, 16, width of the rising-edge count.
- ACC_W, 24, width of the energy accumulator.
- E_PER_TOGGLE, 3, energy units charged per 0->1 transition of sig_in.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  monitored gate output (e.g. inverter Y); asynchronous to clk.
- start  in  1  one-cycle request to begin a measurement window.
- busy  out  1  high while in MEASURE.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_count  out  CNT_W  rising edges counted in the window.
- rpt_energy  out  ACC_W  accumulated energy for the window.
- overflow  out  1  count or energy saturated during the window.

Function
REQ-003 sig_in SHALL pass through a 2-flop synchronizer; a rise SHALL be the synchronized value 1 with its previous sample 0.
REQ-004 A sig_in level sampled at edge N SHALL reach the second sync flop at edge N+1; the rise SHALL be counted at edge N+2.
REQ-005 The FSM SHALL have exactly three states: IDLE, MEASURE, REPORT.
REQ-006 IDLE: start=1 SHALL clear the count, energy, overflow and window counter, and enter MEASURE at the next edge.
REQ-007 MEASURE: the window counter SHALL increment every cycle, and each detected rise SHALL add 1 to the count and E_PER_TOGGLE to the energy.
REQ-008 Rises SHALL be counted only in cycles spent in MEASURE; rises in IDLE and REPORT SHALL be discarded.
REQ-009 When the window counter equals WINDOW-1, a rise in that same cycle SHALL be counted, results SHALL be latched to the rpt_* outputs, and the FSM SHALL enter REPORT.
REQ-010 Count and energy SHALL saturate at all-ones, and either saturation SHALL set overflow for that report.
REQ-011 REPORT: rpt_valid SHALL be 1, and rpt_count, rpt_energy and overflow SHALL stay stable until rpt_valid&&rpt_ready.
REQ-012 On rpt_valid&&rpt_ready the FSM SHALL enter IDLE and deassert rpt_valid at the next edge.
REQ-013 start SHALL be ignored in MEASURE and REPORT.
REQ-014 busy SHALL equal (state==MEASURE).

Reset
REQ-015 reset SHALL force IDLE, clear both synchronizer flops and the edge-history flop, and zero busy, rpt_valid, rpt_count, rpt_energy, overflow and all internal counters.
REQ-016 reset SHALL take priority over start, rpt_ready and any in-progress window; an aborted window SHALL produce no report.

Configuration
REQ-017 With TEM_GLITCH_FILTER_EN defined, the synchronized signal SHALL change only after two consecutive identical samples, so rise latency becomes N+3 and a high pulse of one clk cycle or less SHALL NOT be counted.
REQ-018 Without TEM_GLITCH_FILTER_EN, the behaviour SHALL be exactly REQ-003/REQ-004.

Structure
REQ-019 Package tem_pkg SHALL hold the FSM state encoding (IDLE=2'd0, MEASURE=2'd1, REPORT=2'd2) and the default parameter constants.
REQ-020 Sub-module tem_sync_edge SHALL contain the synchronizer, the optional glitch filter and the rise detector, with one output rise_pulse.
REQ-021 toggle_energy_meter SHALL contain the FSM, window counter, accumulators and report registers.

Verification (WINDOW=16, E_PER_TOGGLE=3 unless stated)
REQ-022 Reset, then start, then 4 pulses each 3 cycles high inside the window -> rpt_valid at cycle 16 after start, rpt_count=4, rpt_energy=12, overflow=0.
REQ-023 start with sig_in held low -> rpt_count=0, rpt_energy=0; busy high for exactly 16 cycles.
REQ-024 rpt_ready low for 5 cycles in REPORT, with start pulsed during REPORT -> outputs stable and state unchanged; ready=1 -> IDLE next cycle, no new window.
REQ-025 CNT_W=3, sig_in toggling every 2 cycles (8 rises) -> rpt_count=7, overflow=1, rpt_energy=24.
REQ-026 reset asserted at window cycle 7 -> next cycle IDLE, all outputs 0, no rpt_valid afterwards.
REQ-027 One-cycle high glitch on sig_in -> rpt_count=1 without TEM_GLITCH_FILTER_EN, rpt_count=0 with it.

Source files
------------

// File: rtl/tem_pkg.sv
// tem_pkg: shared definitions for the toggle energy meter.
//   - FSM state encoding used by toggle_energy_meter
//   - default values for the WINDOW / CNT_W / ACC_W / E_PER_TOGGLE parameters
// Optional build macro used elsewhere in this slice: TEM_GLITCH_FILTER_EN
// (enables the two-sample glitch filter inside tem_sync_edge).
package tem_pkg;

   typedef logic [1:0] tem_state_t;

   localparam tem_state_t ST_IDLE    = 2'd0;
   localparam tem_state_t ST_MEASURE = 2'd1;
   localparam tem_state_t ST_REPORT  = 2'd2;

   localparam int TEM_WINDOW       = 256;
   localparam int TEM_CNT_W        = 16;
   localparam int TEM_ACC_W        = 24;
   localparam int TEM_E_PER_TOGGLE = 3;

endpackage

// File: rtl/tem_sync_edge.sv
// tem_sync_edge: brings the asynchronous monitored signal into the clk domain
// and produces a one-cycle pulse for every 0->1 transition.
// Ports:
//   clk        in   sampling clock
//   reset      in   synchronous, active-high; clears every flop
//   sig_in     in   monitored signal, asynchronous to clk
//   rise_pulse out  high for the cycle in which a synchronized rise is seen
// Build macro TEM_GLITCH_FILTER_EN: when defined, the synchronized level only
// follows the input after two consecutive identical samples, which adds one
// cycle of latency and suppresses high pulses of one clk cycle or less.
module tem_sync_edge
   import tem_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic rise_pulse
);

   logic sync_p0;
   logic sync_p1;

`ifdef TEM_GLITCH_FILTER_EN
   logic filt_p2;
   logic hist_p3;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         filt_p2 <= 1'b0;
         hist_p3 <= 1'b0;
      end else begin
         // stage p0/p1: two-flop synchronizer
         sync_p0 <= sig_in;
         sync_p1 <= sync_p0;
         // stage p2: accept a new level only when two successive samples agree
         if (sync_p0 == sync_p1) begin
            filt_p2 <= sync_p1;
         end
         // stage p3: edge history
         hist_p3 <= filt_p2;
      end
   end

   assign rise_pulse = filt_p2 & ~hist_p3;
`else
   logic hist_p2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         hist_p2 <= 1'b0;
      end else begin
         // stage p0/p1: two-flop synchronizer
         sync_p0 <= sig_in;
         sync_p1 <= sync_p0;
         // stage p2: edge history
         hist_p2 <= sync_p1;
      end
   end

   assign rise_pulse = sync_p1 & ~hist_p2;
`endif

endmodule

// File: rtl/toggle_energy_meter.sv
// toggle_energy_meter: counts 0->1 transitions of a monitored gate output over
// a fixed window of clk cycles and charges E_PER_TOGGLE energy units per rise.
// Results are offered through a valid/ready report port.
// Ports:
//   clk        in   single clock
//   reset      in   synchronous, active-high; aborts any window, no report
//   sig_in     in   monitored signal (asynchronous)
//   start      in   one-cycle request to open a window (honoured in IDLE only)
//   busy       out  high while the window is being measured
//   rpt_valid  out  report available (held until rpt_ready)
//   rpt_ready  in   consumer accepts the report
//   rpt_count  out  rising edges counted in the window (saturating)
//   rpt_energy out  accumulated energy for the window (saturating)
//   overflow   out  count or energy saturated during the window
// Build macro TEM_GLITCH_FILTER_EN: selects the glitch-filtered synchronizer
// in tem_sync_edge (rise latency grows by one cycle).
module toggle_energy_meter
   import tem_pkg::*;
#(
   parameter int WINDOW       = TEM_WINDOW,
   parameter int CNT_W        = TEM_CNT_W,
   parameter int ACC_W        = TEM_ACC_W,
   parameter int E_PER_TOGGLE = TEM_E_PER_TOGGLE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic [ACC_W-1:0] rpt_energy,
   output logic             overflow
);

   localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [ACC_W:0]   E_INC    = (ACC_W + 1)'(E_PER_TOGGLE);

   // Returns {saturated, next_count}; sticks at all-ones.
   function automatic logic [CNT_W:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc_cnt = {1'b1, v};
      end else begin
         sat_inc_cnt = {1'b0, v + CNT_W'(1)};
      end
   endfunction

   // Returns {saturated, next_energy}; the extra MSB of the sum flags wrap.
   function automatic logic [ACC_W:0] sat_add_energy(input logic [ACC_W-1:0] v);
      logic [ACC_W:0] sum;
      sum = {1'b0, v} + E_INC;
      if (sum[ACC_W]) begin
         sat_add_energy = {1'b1, {ACC_W{1'b1}}};
      end else begin
         sat_add_energy = sum;
      end
   endfunction

   tem_state_t       state;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] acc_cnt;
   logic [ACC_W-1:0] acc_energy;
   logic             acc_ovf;

   logic             rise_pulse;
   logic [CNT_W:0]   cnt_step;
   logic [ACC_W:0]   energy_step;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ACC_W-1:0] energy_nxt;
   logic             ovf_nxt;

   tem_sync_edge u_sync_edge (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in),
      .rise_pulse (rise_pulse)
   );

   // Next accumulator values if this cycle is a measured cycle. Used both for
   // the running update and for the final latch, so a rise in the last window
   // cycle still lands in the report.
   always_comb begin
      cnt_step    = sat_inc_cnt(acc_cnt);
      energy_step = sat_add_energy(acc_energy);
      cnt_nxt     = acc_cnt;
      energy_nxt  = acc_energy;
      ovf_nxt     = acc_ovf;
      if (rise_pulse) begin
         cnt_nxt    = cnt_step[CNT_W-1:0];
         energy_nxt = energy_step[ACC_W-1:0];
         ovf_nxt    = acc_ovf | cnt_step[CNT_W] | energy_step[ACC_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         win_cnt    <= '0;
         acc_cnt    <= '0;
         acc_energy <= '0;
         acc_ovf    <= 1'b0;
         rpt_count  <= '0;
         rpt_energy <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  win_cnt    <= '0;
                  acc_cnt    <= '0;
                  acc_energy <= '0;
                  acc_ovf    <= 1'b0;
                  rpt_count  <= '0;
                  rpt_energy <= '0;
                  overflow   <= 1'b0;
                  state      <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               win_cnt    <= win_cnt + WIN_W'(1);
               acc_cnt    <= cnt_nxt;
               acc_energy <= energy_nxt;
               acc_ovf    <= ovf_nxt;
               if (win_cnt == WIN_LAST) begin
                  rpt_count  <= cnt_nxt;
                  rpt_energy <= energy_nxt;
                  overflow   <= ovf_nxt;
                  state      <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               // Report registers are only written on the window's last
               // cycle, so they hold here until the handshake.
               if (rpt_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state == ST_MEASURE);
   assign rpt_valid = (state == ST_REPORT);

endmodule

// File: tb/tb_toggle_energy_meter.sv
// tb_toggle_energy_meter: directed, table-driven bench for toggle_energy_meter.
// dut  : WINDOW=16, CNT_W=16, ACC_W=24, E_PER_TOGGLE=3
// dut2 : WINDOW=32, CNT_W=3 -- 32-cycle window so a 4-cycle toggle period
//        yields 8 rises and the 3-bit count saturates.
module tb_toggle_energy_meter;

`ifdef TEM_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif

   logic        clk;
   logic        reset;
   logic        sig_in;
   logic        start;
   logic        rpt_ready;
   logic        busy;
   logic        rpt_valid;
   logic [15:0] rpt_count;
   logic [23:0] rpt_energy;
   logic        overflow;

   logic        sig2;
   logic        start2;
   logic        ready2;
   logic        busy2;
   logic        valid2;
   logic [2:0]  count2;
   logic [23:0] energy2;
   logic        ovf2;

   int checks   = 0;
   int failures = 0;

   toggle_energy_meter #(
      .WINDOW(16), .CNT_W(16), .ACC_W(24), .E_PER_TOGGLE(3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in),
      .start      (start),
      .busy       (busy),
      .rpt_valid  (rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_count  (rpt_count),
      .rpt_energy (rpt_energy),
      .overflow   (overflow)
   );

   toggle_energy_meter #(
      .WINDOW(32), .CNT_W(3), .ACC_W(24), .E_PER_TOGGLE(3)
   ) dut2 (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig2),
      .start      (start2),
      .busy       (busy2),
      .rpt_valid  (valid2),
      .rpt_ready  (ready2),
      .rpt_count  (count2),
      .rpt_energy (energy2),
      .overflow   (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] pat;      // pat[k-1] is the sig_in level sampled at edge k
      int unsigned exp_cnt;
      int unsigned exp_energy;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Opens a window on dut, drives pat over its 16 cycles, optionally pulses
   // start at edge mid_start, and returns the number of samples with busy=1
   // taken from the start edge through edge 16.
   task automatic run_window(input logic [15:0] pat, input int mid_start,
                             output int busy_cycles);
      busy_cycles = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (busy) busy_cycles++;
      for (int k = 1; k <= 16; k++) begin
         sig_in = pat[k-1];
         start  = (k == mid_start);
         tick();
         if (busy) busy_cycles++;
      end
      sig_in = 1'b0;
      start  = 1'b0;
   endtask

   initial begin
      int  bc;
      bit  hold_ok;
      bit  idle_ok;

      vecs[0] = '{"four_pulses",       16'h7777, 4, 12, 1'b0};
      vecs[1] = '{"all_low",           16'h0000, 0,  0, 1'b0};
      vecs[2] = '{"long_pulse",        16'h03FF, 1,  3, 1'b0};
      vecs[3] = '{"toggle_every_2",    16'h3333, 4, 12, 1'b0};
      vecs[4] = '{"last_cycle_rise",   16'h6000, (FILT != 0) ? 0 : 1,
                                                 (FILT != 0) ? 0 : 3, 1'b0};
      vecs[5] = '{"after_window_rise", 16'hC000, 0,  0, 1'b0};

      reset = 1'b1; sig_in = 1'b0; start = 1'b0; rpt_ready = 1'b0;
      sig2 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
      repeat (3) tick();

      check("reset_busy",     busy,       0);
      check("reset_valid",    rpt_valid,  0);
      check("reset_count",    rpt_count,  0);
      check("reset_energy",   rpt_energy, 0);
      check("reset_overflow", overflow,   0);
      check("reset_busy2",    busy2,      0);
      check("reset_valid2",   valid2,     0);
      reset = 1'b0;
      repeat (2) tick();

      // Table-driven windows
      for (int i = 0; i < 6; i++) begin
         run_window(vecs[i].pat, -1, bc);
         check({vecs[i].name, "_busy_cycles"}, bc, 16);
         check({vecs[i].name, "_valid"},  rpt_valid,  1);
         check({vecs[i].name, "_count"},  rpt_count,  vecs[i].exp_cnt);
         check({vecs[i].name, "_energy"}, rpt_energy, vecs[i].exp_energy);
         check({vecs[i].name, "_ovf"},    overflow,   vecs[i].exp_ovf);
         rpt_ready = 1'b1;
         tick();
         rpt_ready = 1'b0;
         check({vecs[i].name, "_valid_drop"}, rpt_valid, 0);
         repeat (3) tick();
      end

      // Start ignored in MEASURE, report held while not ready, start ignored in REPORT
      run_window(16'h0070, 5, bc);
      check("hold_busy_cycles", bc, 16);
      check("hold_count0", rpt_count, 1);
      check("hold_energy0", rpt_energy, 3);
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick();
         if (rpt_valid !== 1'b1 || busy !== 1'b0 || rpt_count !== 16'd1 ||
             rpt_energy !== 24'd3 || overflow !== 1'b0) hold_ok = 1'b0;
      end
      start = 1'b0;
      check("report_hold_stable", hold_ok, 1);
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      check("hold_release_valid", rpt_valid, 0);
      check("hold_release_busy",  busy,      0);
      idle_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy !== 1'b0 || rpt_valid !== 1'b0) idle_ok = 1'b0;
      end
      check("no_new_window", idle_ok, 1);

      // Reset at window cycle 7 aborts without a report
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         sig_in = (k >= 2 && k <= 4);
         tick();
      end
      sig_in = 1'b0;
      check("abort_busy_before", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy",     busy,       0);
      check("abort_valid",    rpt_valid,  0);
      check("abort_count",    rpt_count,  0);
      check("abort_energy",   rpt_energy, 0);
      check("abort_overflow", overflow,   0);
      idle_ok = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (rpt_valid !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
      end
      check("abort_no_report", idle_ok, 1);

      // Reset has priority over a simultaneous start
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("reset_beats_start", busy, 0);
      tick();
      check("reset_beats_start_idle", busy, 0);

      // Single-cycle glitch: counted without the filter, rejected with it
      run_window(16'h0004, -1, bc);
      check("glitch_valid", rpt_valid, 1);
      check("glitch_count", rpt_count, (FILT != 0) ? 0 : 1);
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      repeat (3) tick();

      // Count saturation on the 3-bit instance: 8 rises, count sticks at 7
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         sig2 = (((k - 1) % 4) < 2);
         tick();
         if (k == 31) check("sat_busy_before_end", busy2, 1);
      end
      sig2 = 1'b0;
      check("sat_valid",  valid2,  1);
      check("sat_busy",   busy2,   0);
      check("sat_count",  count2,  7);
      check("sat_energy", energy2, 24);
      check("sat_ovf",    ovf2,    1);
      ready2 = 1'b1;
      tick();
      ready2 = 1'b0;
      check("sat_valid_drop", valid2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
